// File: rtl/dsp_pkg.sv
// Shared definitions for the MAC pipeline: OPMODE field layout, Z-select
// encodings and the saturation limits used by the post-adder.
package dsp_pkg;

  localparam int OPM_W         = 5;
  localparam int OPM_PREADD_EN = 0;
  localparam int OPM_PRE_SUB   = 1;
  localparam int OPM_ZSEL_LO   = 2;
  localparam int OPM_ZSEL_HI   = 3;
  localparam int OPM_POST_SUB  = 4;

  typedef enum logic [1:0] {
    ZSEL_ZERO = 2'b00,
    ZSEL_C    = 2'b01,
    ZSEL_P    = 2'b10,
    ZSEL_PCIN = 2'b11
  } zsel_e;

  // Limits are built at a generous fixed width and truncated by the user
  // to its own WIDTH_P, so one function serves every parametrisation.
  localparam int SAT_LIM_W = 128;
  typedef logic signed [SAT_LIM_W-1:0] sat_lim_t;

  function automatic sat_lim_t sat_max(input int width);
    return (sat_lim_t'(1) <<< (width - 1)) - sat_lim_t'(1);
  endfunction

  function automatic sat_lim_t sat_min(input int width);
    return -(sat_lim_t'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/dsp_postadd_sat.sv
// Post-adder: Z +/- (M + carry) evaluated one bit wider than the result so
// overflow is visible, then either clamped (SAT_EN!=0) or wrapped.
module dsp_postadd_sat
  import dsp_pkg::*;
#(
  parameter int WIDTH_P = 48,
  parameter int SAT_EN  = 1
) (
  input  logic signed [WIDTH_P-1:0] i_z,
  input  logic signed [WIDTH_P-1:0] i_m,
  input  logic                      i_carry,
  input  logic                      i_sub,
  output logic signed [WIDTH_P-1:0] o_p,
  output logic                      o_ovf
);

  localparam int WS = WIDTH_P + 1;

  localparam sat_lim_t LIM_POS_W = sat_max(WIDTH_P);
  localparam sat_lim_t LIM_NEG_W = sat_min(WIDTH_P);
  localparam logic [WIDTH_P-1:0] LIM_POS = LIM_POS_W[WIDTH_P-1:0];
  localparam logic [WIDTH_P-1:0] LIM_NEG = LIM_NEG_W[WIDTH_P-1:0];

  logic [WS-1:0] w_z_x;
  logic [WS-1:0] w_mc_x;
  logic [WS-1:0] w_sum;

  // Wide sum and overflow flag (top two bits disagree => out of range)
  always_comb begin
    w_z_x  = WS'(i_z);
    w_mc_x = WS'(i_m) + WS'(i_carry);
    if (i_sub) begin
      w_sum = w_z_x - w_mc_x;
    end else begin
      w_sum = w_z_x + w_mc_x;
    end
    o_ovf = w_sum[WS-1] ^ w_sum[WS-2];
  end

  // Result select: low bits normally, rail value on saturating overflow
  always_comb begin
    o_p = w_sum[WIDTH_P-1:0];
    if ((SAT_EN != 0) && o_ovf) begin
      o_p = w_sum[WS-1] ? LIM_NEG : LIM_POS;
    end
  end

endmodule

// File: rtl/dsp_mac_pipe.sv
// Three-stage pre-add / multiply / post-add MAC with accumulate, cascade
// input, optional saturation and a sticky overflow flag.
module dsp_mac_pipe
  import dsp_pkg::*;
#(
  parameter int WIDTH_AB = 18,
  parameter int WIDTH_P  = 48,
  parameter int SAT_EN   = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       CE,
  input  logic                       IN_VALID,
  input  logic signed [WIDTH_AB-1:0] A,
  input  logic signed [WIDTH_AB-1:0] B,
  input  logic signed [WIDTH_AB-1:0] D,
  input  logic signed [WIDTH_P-1:0]  C,
  input  logic signed [WIDTH_P-1:0]  PCIN,
  input  logic [OPM_W-1:0]           OPMODE,
  input  logic                       CARRYIN,
  input  logic                       CLR_OVF,
  output logic signed [WIDTH_P-1:0]  P,
  output logic signed [WIDTH_P-1:0]  PCOUT,
  output logic signed [2*WIDTH_AB:0] M,
  output logic signed [WIDTH_AB-1:0] BCOUT,
  output logic                       OUT_VALID,
  output logic                       OVF,
  output logic                       OVF_STICKY
);

  localparam int WPRE = WIDTH_AB + 1;
  localparam int WM   = 2 * WIDTH_AB + 1;

  if (WIDTH_P < 2 * WIDTH_AB + 2) begin : g_bad_width
    $error("dsp_mac_pipe: WIDTH_P must be at least 2*WIDTH_AB+2");
  end

  // Stage 1 registers
  logic signed [WIDTH_AB-1:0] r_a1, r_b1, r_d1;
  logic signed [WIDTH_P-1:0]  r_c1, r_pcin1;
  logic [OPM_W-1:0]           r_op1;
  logic                       r_cin1, r_v1;

  // Stage 2 registers
  logic signed [WM-1:0]       r_m;
  logic signed [WIDTH_P-1:0]  r_c2, r_pcin2;
  logic [OPM_W-1:0]           r_op2;
  logic                       r_cin2, r_v2;

  // Stage 3 registers
  logic signed [WIDTH_P-1:0]  r_p;
  logic                       r_out_valid, r_ovf, r_ovf_sticky;

  logic signed [WPRE-1:0]     w_preadd, w_mul_b;
  logic signed [WM-1:0]       w_prod;
  zsel_e                      w_zsel;
  logic signed [WIDTH_P-1:0]  w_z, w_m_ext, w_sum_p;
  logic                       w_ovf;

  // Stage 1: capture the sample and its control bits
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_a1    <= '0;
      r_b1    <= '0;
      r_d1    <= '0;
      r_c1    <= '0;
      r_pcin1 <= '0;
      r_op1   <= '0;
      r_cin1  <= 1'b0;
      r_v1    <= 1'b0;
    end else if (CE) begin
      r_a1    <= A;
      r_b1    <= B;
      r_d1    <= D;
      r_c1    <= C;
      r_pcin1 <= PCIN;
      r_op1   <= OPMODE;
      r_cin1  <= CARRYIN;
      r_v1    <= IN_VALID;
    end
  end

  // Pre-adder and multiplier; both operands widened first so the product is exact
  always_comb begin
    if (r_op1[OPM_PRE_SUB]) begin
      w_preadd = WPRE'(r_d1) - WPRE'(r_b1);
    end else begin
      w_preadd = WPRE'(r_d1) + WPRE'(r_b1);
    end
    w_mul_b = r_op1[OPM_PREADD_EN] ? w_preadd : WPRE'(r_b1);
    w_prod  = WM'(r_a1) * WM'(w_mul_b);
  end

  // Stage 2: register the product and carry the post-adder controls along
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_m     <= '0;
      r_c2    <= '0;
      r_pcin2 <= '0;
      r_op2   <= '0;
      r_cin2  <= 1'b0;
      r_v2    <= 1'b0;
    end else if (CE) begin
      r_m     <= w_prod;
      r_c2    <= r_c1;
      r_pcin2 <= r_pcin1;
      r_op2   <= r_op1;
      r_cin2  <= r_cin1;
      r_v2    <= r_v1;
    end
  end

  // Z operand select; accumulate reads the live P register, so back-to-back
  // samples chain without a hazard
  always_comb begin
    w_zsel  = zsel_e'(r_op2[OPM_ZSEL_HI:OPM_ZSEL_LO]);
    w_m_ext = WIDTH_P'(r_m);
    case (w_zsel)
      ZSEL_ZERO: w_z = '0;
      ZSEL_C:    w_z = r_c2;
      ZSEL_P:    w_z = r_p;
      ZSEL_PCIN: w_z = r_pcin2;
      default:   w_z = '0;
    endcase
  end

  dsp_postadd_sat #(
    .WIDTH_P (WIDTH_P),
    .SAT_EN  (SAT_EN)
  ) u_postadd (
    .i_z     (w_z),
    .i_m     (w_m_ext),
    .i_carry (r_cin2),
    .i_sub   (r_op2[OPM_POST_SUB]),
    .o_p     (w_sum_p),
    .o_ovf   (w_ovf)
  );

  // Stage 3: P only moves on valid samples so bubbles do not disturb accumulation
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_p         <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (CE) begin
      r_out_valid <= r_v2;
      if (r_v2) begin
        r_p   <= w_sum_p;
        r_ovf <= w_ovf;
      end else begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Sticky overflow: clear works even while stalled, a same-cycle overflow wins
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf_sticky <= 1'b0;
    end else begin
      r_ovf_sticky <= (r_ovf_sticky & ~CLR_OVF) | (CE & r_v2 & w_ovf);
    end
  end

  assign P          = r_p;
  assign PCOUT      = r_p;
  assign M          = r_m;
  assign BCOUT      = r_b1;
  assign OUT_VALID  = r_out_valid;
  assign OVF        = r_ovf;
  assign OVF_STICKY = r_ovf_sticky;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Bench for dsp_mac_pipe: a saturating and a wrapping instance share all
// inputs and are compared every cycle against a transaction-level model.
module tb_dsp_mac_pipe;

  localparam longint PMAX  = 64'sd140737488355327;
  localparam longint PMIN  = -64'sd140737488355328;
  localparam longint TWO48 = 64'sd281474976710656;

  typedef struct {
    bit       v;
    longint   a, b, d, c, pcin;
    bit [4:0] op;
    bit       cin;
  } rec_t;

  logic CLK = 1'b0;
  logic RST, CE, IN_VALID, CARRYIN, CLR_OVF;
  logic signed [17:0] A, B, D;
  logic signed [47:0] C, PCIN;
  logic [4:0] OPMODE;

  logic signed [47:0] P_s, PCOUT_s, P_w, PCOUT_w;
  logic signed [36:0] M_s, M_w;
  logic signed [17:0] BC_s, BC_w;
  logic OV_s, OVF_s, ST_s, OV_w, OVF_w, ST_w;

  int errors = 0;
  int checks = 0;

  rec_t   q[$];
  longint mp_s, mp_w;
  bit     mov, movf_s, movf_w, mst_s, mst_w;

  always #5 CLK = ~CLK;

  dsp_mac_pipe #(.WIDTH_AB(18), .WIDTH_P(48), .SAT_EN(1)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .CARRYIN(CARRYIN), .CLR_OVF(CLR_OVF),
    .P(P_s), .PCOUT(PCOUT_s), .M(M_s), .BCOUT(BC_s),
    .OUT_VALID(OV_s), .OVF(OVF_s), .OVF_STICKY(ST_s)
  );

  dsp_mac_pipe #(.WIDTH_AB(18), .WIDTH_P(48), .SAT_EN(0)) dut_w (
    .CLK(CLK), .RST(RST), .CE(CE), .IN_VALID(IN_VALID),
    .A(A), .B(B), .D(D), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
    .CARRYIN(CARRYIN), .CLR_OVF(CLR_OVF),
    .P(P_w), .PCOUT(PCOUT_w), .M(M_w), .BCOUT(BC_w),
    .OUT_VALID(OV_w), .OVF(OVF_w), .OVF_STICKY(ST_w)
  );

  function automatic longint prod(input rec_t r);
    longint pre, mb;
    pre = r.op[1] ? (r.d - r.b) : (r.d + r.b);
    mb  = r.op[0] ? pre : r.b;
    return r.a * mb;
  endfunction

  function automatic void post(input rec_t r, input longint pp, input bit sat,
                               output longint pn, output bit ov);
    longint z, s;
    case (r.op[3:2])
      2'd0:    z = 0;
      2'd1:    z = r.c;
      2'd2:    z = pp;
      default: z = r.pcin;
    endcase
    if (r.op[4]) s = z - (prod(r) + longint'(r.cin));
    else         s = z + prod(r) + longint'(r.cin);
    ov = (s > PMAX) || (s < PMIN);
    if (!ov)      pn = s;
    else if (sat) pn = (s > 0) ? PMAX : PMIN;
    else          pn = (s > 0) ? (s - TWO48) : (s + TWO48);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [47:0] e;
    logic [36:0] em;
    logic [17:0] eb;
    longint t;
    e = mp_s[47:0];
    chk("p_sat", $unsigned(P_s), e);
    chk("pcout_sat", $unsigned(PCOUT_s), e);
    e = mp_w[47:0];
    chk("p_wrap", $unsigned(P_w), e);
    chk("pcout_wrap", $unsigned(PCOUT_w), e);
    chk("out_valid_sat", OV_s, mov);
    chk("out_valid_wrap", OV_w, mov);
    chk("ovf_sat", OVF_s, movf_s);
    chk("ovf_wrap", OVF_w, movf_w);
    chk("sticky_sat", ST_s, mst_s);
    chk("sticky_wrap", ST_w, mst_w);
    t  = (q.size() == 2) ? prod(q[0]) : 0;
    em = t[36:0];
    chk("m_sat", $unsigned(M_s), em);
    chk("m_wrap", $unsigned(M_w), em);
    t  = (q.size() >= 1) ? q[q.size()-1].b : 0;
    eb = t[17:0];
    chk("bcout", $unsigned(BC_s), eb);
    chk("bcout_wrap", $unsigned(BC_w), eb);
  endtask

  // One clock: apply controls, advance the model on the edge, check after it
  task automatic step(input bit ce, input bit rst, input bit clr);
    rec_t   r;
    longint np;
    bit     o;
    CE = ce; RST = rst; CLR_OVF = clr;
    @(posedge CLK);
    if (rst) begin
      q.delete();
      mp_s = 0; mp_w = 0; mov = 0;
      movf_s = 0; movf_w = 0; mst_s = 0; mst_w = 0;
    end else begin
      if (clr) begin mst_s = 0; mst_w = 0; end
      if (ce) begin
        r.v = IN_VALID; r.a = A; r.b = B; r.d = D; r.c = C; r.pcin = PCIN;
        r.op = OPMODE; r.cin = CARRYIN;
        q.push_back(r);
        mov = 0; movf_s = 0; movf_w = 0;
        if (q.size() == 3) begin
          r = q.pop_front();
          if (r.v) begin
            post(r, mp_s, 1'b1, np, o); mp_s = np; movf_s = o;
            post(r, mp_w, 1'b0, np, o); mp_w = np; movf_w = o;
            mov = 1;
          end
        end
        mst_s = mst_s | movf_s;
        mst_w = mst_w | movf_w;
      end
    end
    #1;
    check_all();
  endtask

  task automatic set_sample(input bit v, input int a, input int b, input int d,
                            input longint c, input longint pcin,
                            input bit [4:0] op, input bit cin);
    IN_VALID = v; A = 18'(a); B = 18'(b); D = 18'(d);
    C = 48'(c); PCIN = 48'(pcin); OPMODE = op; CARRYIN = cin;
  endtask

  task automatic rand_sample();
    IN_VALID = ($urandom_range(0, 3) != 0);
    A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
    OPMODE = 5'($urandom); CARRYIN = 1'($urandom);
    case ($urandom_range(0, 7))
      0:       C = 48'sh7FFF_FFFF_FF00 + 48'($urandom_range(0, 255));
      1:       C = 48'sh8000_0000_0100 - 48'($urandom_range(0, 255));
      default: C = 48'({$urandom, $urandom});
    endcase
    PCIN = ($urandom_range(0, 5) == 0) ? 48'sh7FFF_FFFF_FFFF : 48'({$urandom, $urandom});
  endtask

  initial begin
    set_sample(0, 0, 0, 0, 0, 0, 5'd0, 0);
    CE = 0; RST = 1; CLR_OVF = 0;

    // Reset with CE low still clears everything
    step(0, 1, 0);
    step(0, 1, 0);
    chk("reset_p", $unsigned(P_s), 64'd0);
    chk("reset_out_valid", OV_s, 1'b0);
    chk("reset_sticky", ST_s, 1'b0);

    // Pre-add: 10*(3+15)+12
    set_sample(1, 10, 15, 3, 12, 0, 5'b00101, 0);
    step(1, 0, 0);
    IN_VALID = 0;
    step(1, 0, 0);
    chk("preadd_not_early", OV_s, 1'b0);
    step(1, 0, 0);
    chk("preadd_p", $unsigned(P_s), 64'd192);
    chk("preadd_valid", OV_s, 1'b1);
    step(1, 0, 0);
    chk("preadd_valid_one_cycle", OV_s, 1'b0);
    chk("preadd_p_hold", $unsigned(P_s), 64'd192);

    // Accumulate four 2*3 products, then a bubble
    step(1, 1, 0);
    set_sample(1, 2, 3, 0, 0, 0, 5'b01000, 0);
    for (int k = 1; k <= 7; k++) begin
      if (k == 5) IN_VALID = 0;
      step(1, 0, 0);
      if (k >= 3 && k <= 6) begin
        chk("accum_p", $unsigned(P_s), 64'(6 * (k - 2)));
        chk("accum_valid", OV_s, 1'b1);
      end
    end
    chk("bubble_p_hold", $unsigned(P_s), 64'd24);
    chk("bubble_valid", OV_s, 1'b0);

    // Saturate vs wrap at the positive rail
    step(1, 1, 0);
    set_sample(1, 1, 1, 0, PMAX, 0, 5'b00100, 0);
    step(1, 0, 0);
    IN_VALID = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    chk("sat_p", $unsigned(P_s), 64'h7FFF_FFFF_FFFF);
    chk("sat_ovf", OVF_s, 1'b1);
    chk("sat_sticky", ST_s, 1'b1);
    chk("wrap_p", $unsigned(P_w), 64'h8000_0000_0000);
    step(1, 0, 0);
    chk("ovf_bubble", OVF_s, 1'b0);
    chk("sticky_kept", ST_s, 1'b1);
    step(0, 0, 1);
    chk("clr_while_stalled", ST_s, 1'b0);

    // Subtract with carry: 100 - (4*(20-5) + 1)
    set_sample(1, 4, 5, 20, 0, 100, 5'b11111, 1);
    step(1, 0, 0);
    IN_VALID = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    chk("subcarry_p", $unsigned(P_s), 64'd39);

    // Stall mid-stream for five cycles
    step(1, 1, 0);
    for (int k = 0; k < 14; k++) begin
      rand_sample();
      if (k < 6) begin
        IN_VALID = 1;
        OPMODE[3:2] = 2'b10;
      end
      step((k < 3 || k > 7) ? 1'b1 : 1'b0, 0, 0);
    end

    // Reset with two samples in flight after an overflow
    set_sample(1, 1, 1, 0, PMAX, 0, 5'b00100, 0);
    step(1, 0, 0);
    IN_VALID = 0;
    step(1, 0, 0);
    step(1, 0, 0);
    set_sample(1, 2, 3, 0, 0, 0, 5'b00000, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    IN_VALID = 0;
    step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(1, 0, 0);
      chk("flush_no_valid", OV_s, 1'b0);
      chk("flush_p", $unsigned(P_s), 64'd0);
      chk("flush_sticky", ST_s, 1'b0);
    end

    // Random traffic with stalls, clears and occasional resets
    for (int k = 0; k < 600; k++) begin
      rand_sample();
      step(($urandom_range(0, 6) != 0), ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dsp_mac_pipe.md
DSP_MAC_PIPE -- requirements
Module: dsp_mac_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH_AB, default 18, giving the signed width of A, B and D.
REQ-002 The block SHALL have parameter WIDTH_P, default 48, giving the signed width of C, PCIN, P and PCOUT; legal only when WIDTH_P >= 2*WIDTH_AB+2.
REQ-003 The block SHALL have parameter SAT_EN, default 1, where 1 means the post-adder saturates and 0 means it wraps.
REQ-004 The block SHALL have the following ports, clock and reset first:
- CLK  in  1  rising-edge clock.
- RST  in  1  reset; synchronous, active-high.
- CE  in  1  global clock enable; 0 stalls every register.
- IN_VALID  in  1  sample on A/B/D/C/PCIN/OPMODE/CARRYIN is valid.
- A, B, D  in  WIDTH_AB  signed operands.
- C, PCIN  in  WIDTH_P  signed post-adder operands.
- OPMODE  in  5  per-sample mode, described in REQ-006.
- CARRYIN  in  1  post-adder carry.
- CLR_OVF  in  1  clears OVF_STICKY.
- P, PCOUT  out  WIDTH_P  result; PCOUT is identical to P.
- M  out  2*WIDTH_AB+1  registered product.
- BCOUT  out  WIDTH_AB  stage-1 B register.
- OUT_VALID  out  1  P holds a new result.
- OVF  out  1  the current result overflowed.
- OVF_STICKY  out  1  an overflow has occurred since reset or the last CLR_OVF.

Function
REQ-005 The block SHALL implement a 3-stage pipeline, active only on cycles with CE=1:
- S1 registers A, B, D, C, PCIN, OPMODE, CARRYIN and IN_VALID.
- S2 computes the pre-adder and multiply, and registers M.
- S3 computes the post-adder and registers P.
REQ-006 OPMODE SHALL be decoded as follows:
- [0] PREADD_EN: 1 means the multiplier B input is the pre-adder output; 0 means it is B sign-extended to WIDTH_AB+1 bits.
- [1] PRE_SUB: 0 gives D+B; 1 gives D-B.
- [3:2] Z select: 00 zero, 01 C, 10 P (accumulate), 11 PCIN.
- [4] POST_SUB: 0 gives Z+M+CARRYIN; 1 gives Z-(M+CARRYIN).
REQ-007 The pre-adder SHALL be WIDTH_AB+1 bits signed, the product SHALL be A*preadd at 2*WIDTH_AB+1 bits signed, and the post-adder SHALL sign-extend M to WIDTH_P and compute at WIDTH_P+1 bits.
REQ-008 OUT_VALID SHALL assert exactly 3 CE=1 cycles after a sampled IN_VALID=1, with zero throughput loss at one sample per cycle.
REQ-009 On a bubble (IN_VALID=0 at S3), P SHALL hold its value and OUT_VALID SHALL be 0, so accumulation skips bubbles.
REQ-010 Z=P SHALL use the current P register, so back-to-back valid samples accumulate correctly with no hazard.
REQ-011 Overflow SHALL be detected when the WIDTH_P+1-bit sum falls outside the signed WIDTH_P range.
REQ-012 On overflow with SAT_EN=1, P SHALL clamp to +2^(WIDTH_P-1)-1 or -2^(WIDTH_P-1); with SAT_EN=0, P SHALL take the low WIDTH_P bits.
REQ-013 OVF SHALL be registered alongside P, valid with OUT_VALID, and 0 on bubbles.
REQ-014 OVF_STICKY SHALL set on any OVF, clear on CLR_OVF, and set if both occur in the same cycle.
REQ-015 With CE=0, all pipeline, P, OVF and OVF_STICKY registers SHALL hold, and OUT_VALID SHALL remain at its last value; CLR_OVF SHALL act regardless of CE.

Reset
REQ-016 On RST=1 at a clock edge, regardless of CE, all registers SHALL clear: P, PCOUT, M, BCOUT = 0, and OUT_VALID, OVF, OVF_STICKY = 0.
REQ-017 RST SHALL have priority over CE, IN_VALID and CLR_OVF.
REQ-018 A reset mid-operation SHALL discard all in-flight samples, with no OUT_VALID for them after reset release.
REQ-019 The first sample after RST deasserts SHALL see P=0 for accumulation.

Structure
REQ-020 The OPMODE field positions, the Z-select encodings and the saturation limit functions SHALL live in shared package dsp_pkg.
REQ-021 The post-adder and saturation logic SHALL be one sub-module, dsp_postadd_sat, parametrised by WIDTH_P and SAT_EN; everything else SHALL be inline.

Verification
REQ-022 The bench SHALL cover the following scenarios:
- Pre-add: A=10, B=15, D=3, C=12, OPMODE=5'b00101, one valid -> 3 cycles later P=192 and OUT_VALID=1 for exactly 1 cycle.
- Accumulate: A=2, B=3, OPMODE=5'b01000, 4 consecutive valids -> P=6, 12, 18, 24 on successive cycles; then one bubble -> P holds at 24.
- Saturate (SAT_EN=1): C=2^47-1, A=1, B=1, OPMODE=5'b00100 -> P=2^47-1, OVF=1, OVF_STICKY=1; the same stimulus with SAT_EN=0 -> P=-2^47.
- Subtract/carry: D=20, B=5, A=4, PCIN=100, CARRYIN=1, OPMODE=5'b11111 -> P=100-(60+1)=39.
- Stall: CE=0 for 5 cycles mid-stream -> P, OUT_VALID and M frozen; the results after release are identical to the unstalled run.
- Reset mid-stream: RST=1 for 1 cycle with 2 samples in flight -> P=0, no OUT_VALID for those samples, OVF_STICKY=0.
